// File: rtl/ov7670_pkg.sv
// Shared encodings, bar colours and VGA timing defaults for the OV7670 stream emulator.
package ov7670_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        ACTIVE,
        VFP
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_RAMP     = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_FRAME_ID = 2'd3
    } pattern_t;

    localparam int unsigned COORD_W   = 16;
    localparam int unsigned PIXEL_W   = 16;
    localparam int unsigned BAR_COUNT = 8;

    localparam logic [PIXEL_W-1:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [PIXEL_W-1:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [PIXEL_W-1:0] BAR_CYAN    = 16'h07FF;
    localparam logic [PIXEL_W-1:0] BAR_GREEN   = 16'h07E0;
    localparam logic [PIXEL_W-1:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [PIXEL_W-1:0] BAR_RED     = 16'hF800;
    localparam logic [PIXEL_W-1:0] BAR_BLUE    = 16'h001F;
    localparam logic [PIXEL_W-1:0] BAR_BLACK   = 16'h0000;

    localparam int unsigned DEF_PCLK_DIV = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_BLANK  = 288;
    localparam int unsigned DEF_V_SYNC   = 3;
    localparam int unsigned DEF_V_BP     = 17;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;

    function automatic logic [PIXEL_W-1:0] bar_colour(input logic [2:0] idx);
        logic [PIXEL_W-1:0] colour;
        case (idx)
            3'd0:    colour = BAR_WHITE;
            3'd1:    colour = BAR_YELLOW;
            3'd2:    colour = BAR_CYAN;
            3'd3:    colour = BAR_GREEN;
            3'd4:    colour = BAR_MAGENTA;
            3'd5:    colour = BAR_RED;
            3'd6:    colour = BAR_BLUE;
            default: colour = BAR_BLACK;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational test-pattern source: pixel coordinate, pattern select and frame number to RGB565.
module ov7670_pattern_gen
    import ov7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  pattern_t           select,
    input  logic [7:0]         frame_count,
    output logic [PIXEL_W-1:0] pixel_c
);

    localparam int unsigned BAR_W = (H_ACTIVE >= BAR_COUNT) ? H_ACTIVE / BAR_COUNT : 1;

    logic [COORD_W-1:0] bar_idx;

    always_comb begin
        bar_idx = x / COORD_W'(BAR_W);
        pixel_c = '0;
        case (select)
            PAT_BARS:    pixel_c = (bar_idx < COORD_W'(BAR_COUNT)) ? bar_colour(bar_idx[2:0]) : BAR_BLACK;
            PAT_RAMP:    pixel_c = {x[7:3], x[7:2], x[7:3]};
            // 8x8 cells: bit 3 of x and y toggles the cell colour
            PAT_CHECKER: pixel_c = (((x ^ y) & COORD_W'(8)) != '0) ? 16'hFFFF : 16'h0000;
            default:     pixel_c = {frame_count, frame_count};
        endcase
    end

endmodule

// File: rtl/ov7670_stream_emulator.sv
// Camera-side OV7670 model: PCLK divider, VGA frame timing FSM and RGB565 byte stream.
module ov7670_stream_emulator
    import ov7670_pkg::*;
#(
    parameter int unsigned PCLK_DIV = DEF_PCLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_BLANK  = DEF_H_BLANK,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP
) (
    input  logic       i_clk,
    input  logic       i_n_reset,
    input  logic       i_enable,
    input  logic [1:0] i_pattern,
    output logic       o_pclk,
    output logic       o_vsync,
    output logic       o_href,
    output logic [7:0] o_data,
    output logic       o_frame_done,
    output logic [7:0] o_frame_count
);

    localparam int unsigned LINE_TICKS  = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned FRAME_LINES = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned DIV_W       = $clog2(PCLK_DIV);
    localparam int unsigned H_W         = $clog2(LINE_TICKS + 1);
    localparam int unsigned V_W         = $clog2(FRAME_LINES + 1);

    state_t             state, state_nxt;
    pattern_t           pat, pat_nxt;
    logic [DIV_W-1:0]   div, div_nxt;
    logic [H_W-1:0]     h, h_nxt;
    logic [V_W-1:0]     v, v_nxt, last_line;
    logic               tick;
    logic               pclk_nxt, vsync_nxt, href_nxt, done_nxt;
    logic [7:0]         data_nxt, count_nxt;
    logic [PIXEL_W-1:0] pixel;

    // Tick = the i_clk edge where div wraps, i.e. the PCLK falling edge.
    assign tick = i_enable && (div == DIV_W'(PCLK_DIV - 1));

    ov7670_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_gen (
        .x           (COORD_W'(h_nxt >> 1)),
        .y           (COORD_W'(v_nxt)),
        .select      (pat),
        .frame_count (o_frame_count),
        .pixel_c     (pixel)
    );

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state         <= IDLE;
            pat           <= PAT_BARS;
            div           <= '0;
            h             <= '0;
            v             <= '0;
            o_pclk        <= 1'b0;
            o_vsync       <= 1'b0;
            o_href        <= 1'b0;
            o_data        <= '0;
            o_frame_done  <= 1'b0;
            o_frame_count <= '0;
        end else begin
            state         <= state_nxt;
            pat           <= pat_nxt;
            div           <= div_nxt;
            h             <= h_nxt;
            v             <= v_nxt;
            o_pclk        <= pclk_nxt;
            o_vsync       <= vsync_nxt;
            o_href        <= href_nxt;
            o_data        <= data_nxt;
            o_frame_done  <= done_nxt;
            o_frame_count <= count_nxt;
        end
    end

    // Divider, raster position and vertical state machine.
    always_comb begin
        state_nxt = state;
        pat_nxt   = pat;
        div_nxt   = div;
        h_nxt     = h;
        v_nxt     = v;
        pclk_nxt  = o_pclk;
        done_nxt  = 1'b0;
        count_nxt = o_frame_count;

        case (state)
            VSYNC:   last_line = V_W'(V_SYNC - 1);
            VBP:     last_line = V_W'(V_BP - 1);
            ACTIVE:  last_line = V_W'(V_ACTIVE - 1);
            VFP:     last_line = V_W'(V_FP - 1);
            default: last_line = '0;
        endcase

        if (!i_enable) begin
            state_nxt = IDLE;
            div_nxt   = '0;
            h_nxt     = '0;
            v_nxt     = '0;
            pclk_nxt  = 1'b0;
        end else begin
            div_nxt  = tick ? '0 : div + DIV_W'(1);
            pclk_nxt = (div_nxt >= DIV_W'(PCLK_DIV / 2));
            if (tick) begin
                if (state == IDLE) begin
                    state_nxt = VSYNC;
                    h_nxt     = '0;
                    v_nxt     = '0;
                    pat_nxt   = pattern_t'(i_pattern);
                end else if (h != H_W'(LINE_TICKS - 1)) begin
                    h_nxt = h + H_W'(1);
                end else begin
                    h_nxt = '0;
                    if (v != last_line) begin
                        v_nxt = v + V_W'(1);
                    end else begin
                        v_nxt = '0;
                        case (state)
                            VSYNC:   state_nxt = VBP;
                            VBP:     state_nxt = ACTIVE;
                            ACTIVE:  state_nxt = VFP;
                            default: begin
                                state_nxt = VSYNC;
                                done_nxt  = 1'b1;
                                count_nxt = o_frame_count + 8'd1;
                                pat_nxt   = pattern_t'(i_pattern);
                            end
                        endcase
                    end
                end
            end
        end
    end

    // Sync and data outputs for the position entered on this tick.
    always_comb begin
        vsync_nxt = o_vsync;
        href_nxt  = o_href;
        data_nxt  = o_data;
        if (!i_enable) begin
            vsync_nxt = 1'b0;
            href_nxt  = 1'b0;
            data_nxt  = '0;
        end else if (tick) begin
            vsync_nxt = (state_nxt == VSYNC);
            href_nxt  = (state_nxt == ACTIVE) && (h_nxt < H_W'(2 * H_ACTIVE));
            data_nxt  = href_nxt ? (h_nxt[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
        end
    end

endmodule

// File: tb/tb_ov7670_stream_emulator.sv
// Bench for ov7670_stream_emulator: cycle-level raster model driven by elapsed-cycle arithmetic.
module tb_ov7670_stream_emulator;

    localparam int PCLK_DIV    = 4;
    localparam int H_ACTIVE    = 8;
    localparam int H_BLANK     = 4;
    localparam int V_SYNC      = 1;
    localparam int V_BP        = 1;
    localparam int V_ACTIVE    = 2;
    localparam int V_FP        = 1;
    localparam int L           = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_TICKS = (V_SYNC + V_BP + V_ACTIVE + V_FP) * L;

    localparam logic [15:0] BAR_TAB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    localparam logic [7:0] BAR_BYTES [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                              8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
    localparam logic [7:0] FIRST_BYTES [8] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h00, 8'h00};

    logic       clk = 1'b0;
    logic       i_n_reset;
    logic       i_enable;
    logic [1:0] i_pattern;
    logic       o_pclk, o_vsync, o_href, o_frame_done;
    logic [7:0] o_data, o_frame_count;

    always #5 clk = ~clk;

    ov7670_stream_emulator #(
        .PCLK_DIV (PCLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP)
    ) dut (
        .i_clk         (clk),
        .i_n_reset     (i_n_reset),
        .i_enable      (i_enable),
        .i_pattern     (i_pattern),
        .o_pclk        (o_pclk),
        .o_vsync       (o_vsync),
        .o_href        (o_href),
        .o_data        (o_data),
        .o_frame_done  (o_frame_done),
        .o_frame_count (o_frame_count)
    );

    int checks = 0;
    int errors = 0;
    int c;
    int base_count;
    int latched_pat;
    int model_count;
    int vs_cycles, href_cycles, href_rises, done_pulses;
    logic prev_href;
    bit collect_bars, collect_first;
    logic [7:0] bars_q[$];
    logic [7:0] first_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_pixel(input int pat, input int x, input int y, input int fc);
        int r, g;
        case (pat)
            0: return BAR_TAB[x / (H_ACTIVE / 8)];
            1: begin
                r = (x >> 3) & 31;
                g = (x >> 2) & 63;
                return 16'((r << 11) | (g << 5) | r);
            end
            2: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: return 16'(fc * 257);
        endcase
    endfunction

    task automatic start_session(input int base);
        c            = 0;
        base_count   = base;
        model_count  = base;
        vs_cycles    = 0;
        href_cycles  = 0;
        href_rises   = 0;
        done_pulses  = 0;
        prev_href    = 1'b0;
    endtask

    // One i_clk cycle; outputs sampled on the falling i_clk edge against the raster model.
    task automatic step();
        int t, f, w, line, h, pat_before;
        logic exp_pclk, exp_vsync, exp_href, exp_done;
        logic [7:0] exp_data, exp_count;
        logic [15:0] px;
        pat_before = int'(i_pattern);
        @(posedge clk);
        c++;
        @(negedge clk);
        exp_pclk  = (c % PCLK_DIV) >= PCLK_DIV / 2;
        exp_vsync = 1'b0;
        exp_href  = 1'b0;
        exp_done  = 1'b0;
        exp_data  = 8'h00;
        exp_count = 8'(base_count);
        line      = -1;
        h         = 0;
        if (c >= PCLK_DIV) begin
            t    = c / PCLK_DIV - 1;
            f    = t / FRAME_TICKS;
            w    = t % FRAME_TICKS;
            line = w / L;
            h    = w % L;
            if ((c % PCLK_DIV) == 0 && w == 0) latched_pat = pat_before;
            exp_count = 8'((base_count + f) % 256);
            exp_vsync = line < V_SYNC;
            exp_href  = (line >= V_SYNC + V_BP) && (line < V_SYNC + V_BP + V_ACTIVE) && (h < 2 * H_ACTIVE);
            exp_done  = ((c % PCLK_DIV) == 0) && (t >= FRAME_TICKS) && (w == 0);
            if (exp_href) begin
                px = model_pixel(latched_pat, h / 2, line - V_SYNC - V_BP, int'(exp_count));
                exp_data = (h % 2 == 0) ? px[15:8] : px[7:0];
            end
        end
        model_count = int'(exp_count);
        check("pclk", 16'(o_pclk), 16'(exp_pclk));
        check("vsync", 16'(o_vsync), 16'(exp_vsync));
        check("href", 16'(o_href), 16'(exp_href));
        check("data", 16'(o_data), 16'(exp_data));
        check("frame_done", 16'(o_frame_done), 16'(exp_done));
        check("frame_count", 16'(o_frame_count), 16'(exp_count));
        if (o_vsync) vs_cycles++;
        if (o_href) href_cycles++;
        if (o_href && !prev_href) href_rises++;
        prev_href = o_href;
        if (o_frame_done) done_pulses++;
        if (collect_bars && (c % PCLK_DIV) == 2 && o_href && bars_q.size() < 16) bars_q.push_back(o_data);
        if (collect_first && (c % PCLK_DIV) == 2 && line == V_SYNC + V_BP && h < 2) first_q.push_back(o_data);
    endtask

    task automatic check_all_zero(input string tag, input int count);
        check({tag, "_pclk"}, 16'(o_pclk), 16'h0);
        check({tag, "_vsync"}, 16'(o_vsync), 16'h0);
        check({tag, "_href"}, 16'(o_href), 16'h0);
        check({tag, "_data"}, 16'(o_data), 16'h0);
        check({tag, "_done"}, 16'(o_frame_done), 16'h0);
        check({tag, "_count"}, 16'(o_frame_count), 16'(count));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        c = 0;
        latched_pat = 0;
        collect_bars = 1'b0;
        collect_first = 1'b0;
        i_n_reset = 1'b0;
        i_enable  = 1'b0;
        i_pattern = 2'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset", 0);
        i_n_reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("idle", 0);

        // Session 1: bars frame, random pattern chosen mid-frame for the next frame, enable dropped mid-ACTIVE
        start_session(0);
        collect_bars = 1'b1;
        i_enable = 1'b1;
        repeat (200) step();
        i_pattern = 2'($urandom_range(0, 3));
        repeat (4 * (FRAME_TICKS + 1) - 201) step();
        check("first_vsync_cycles", 16'(vs_cycles), 16'(80));
        check("href_pulses", 16'(href_rises), 16'(2));
        check("href_cycles", 16'(href_cycles), 16'(2 * 16 * PCLK_DIV));
        check("done_before_end", 16'(done_pulses), 16'(0));
        step();
        check("done_once", 16'(done_pulses), 16'(1));
        check("count_one", 16'(o_frame_count), 16'(1));
        collect_bars = 1'b0;
        check("bars_len", 16'(bars_q.size()), 16'(16));
        for (int i = 0; i < 16 && i < bars_q.size(); i++)
            check($sformatf("bars_byte%0d", i), 16'(bars_q[i]), 16'(BAR_BYTES[i]));
        repeat (4 * 41 + 4 * $urandom_range(0, 14) + $urandom_range(0, 3)) step();
        i_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("drop", model_count);
        repeat (6) begin
            @(negedge clk);
            check("drop_done_quiet", 16'(o_frame_done), 16'h0);
            check("drop_vsync_quiet", 16'(o_vsync), 16'h0);
        end

        // Session 2: fresh VSYNC after re-enable, then asynchronous reset mid-frame
        start_session(model_count);
        i_enable = 1'b1;
        repeat (83) step();
        check("reenable_vsync_cycles", 16'(vs_cycles), 16'(80));
        repeat ($urandom_range(50, 250)) step();
        #2;
        i_n_reset = 1'b0;
        #1;
        check_all_zero("async_reset", 0);
        i_enable = 1'b0;
        @(negedge clk);
        i_n_reset = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset", 0);

        // Session 3: frame-id over three frames, checker requested mid-frame 2
        start_session(0);
        collect_first = 1'b1;
        i_pattern = 2'd3;
        i_enable = 1'b1;
        repeat (4 * (2 * FRAME_TICKS + 51)) step();
        i_pattern = 2'd2;
        repeat (4 * (FRAME_TICKS + 60)) step();
        collect_first = 1'b0;
        check("first_pairs_len", 16'(first_q.size()), 16'(8));
        for (int i = 0; i < 8 && i < first_q.size(); i++)
            check($sformatf("first_pair_byte%0d", i), 16'(first_q[i]), 16'(FIRST_BYTES[i]));
        check("final_count", 16'(o_frame_count), 16'(4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
